// File: rtl/regbus_pkg.sv
// Shared types and constants for the RS/RW/EN sensor register bus host.
package regbus_pkg;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, CAPT, RESP} state_t;

    localparam logic [5:0] STA       = 6'd0;
    localparam logic [5:0] TMPH      = 6'd1;
    localparam logic [5:0] TMPL      = 6'd2;
    localparam logic [5:0] CTL       = 6'd5;
    localparam logic [5:0] OFS_1     = 6'd8;
    localparam logic [5:0] OFS_0     = 6'd9;
    localparam logic [5:0] GAIN3_SHA = 6'd19;

    localparam logic [5:0] ADDR_MAX_DEF = 6'd30;
    localparam logic [5:0] WR_MIN_DEF   = 6'd5;

    localparam logic RS_ADDR  = 1'b0;
    localparam logic RS_DATA  = 1'b1;
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef struct packed {
        logic       en;
        logic       rs;
        logic       rw;
        logic [7:0] data;
    } bus_t;

    // Bus pins for the cycle spent in state s; anything but ADDR/DATA leaves the bus idle.
    function automatic bus_t bus_cycle(state_t s, logic [5:0] a, logic wr, logic [7:0] b);
        bus_t r;
        r = '0;
        case (s)
            ADDR: r = '{en: 1'b1, rs: RS_ADDR, rw: RW_WRITE, data: {2'b00, a}};
            DATA: r = '{en: 1'b1, rs: RS_DATA, rw: wr, data: (wr ? b : 8'h00)};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/regbus_host_if.sv
// Command/response port between the on-chip controller and the register bus host.
interface regbus_host_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic        cmd_pair;
    logic [5:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_write, cmd_pair, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_pair, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/regbus_host.sv
// Sole master of the sensor register bus: sequences address/data cycles for
// byte and byte-pair commands and returns read data or an error response.
module regbus_host
    import regbus_pkg::*;
#(
    parameter bit         ADDR_CACHE_EN = 1'b1,
    parameter logic [5:0] ADDR_MAX      = ADDR_MAX_DEF,
    parameter logic [5:0] WR_MIN        = WR_MIN_DEF
) (
    input  logic         clk,
    input  logic         reset,
    regbus_host_if.slave host,
    output logic         bus_en,
    output logic         bus_rs,
    output logic         bus_rw,
    output logic [7:0]   bus_data_out,
    input  logic [7:0]   bus_data_in
);

    state_t      state;
    logic [5:0]  addr;
    logic [5:0]  cache_addr;
    logic        cache_vld;
    logic        write;
    logic        pair;
    logic        second;
    logic [15:0] wdata;
    bus_t        bus_q;

    logic        accept;
    logic        cmd_bad;
    logic        cmd_hit;
    logic        next_hit;
    logic        more;
    logic [5:0]  next_addr;
    logic [7:0]  first_byte;
    logic [7:0]  cur_byte;

    function automatic logic cache_hit(logic vld, logic [5:0] cached, logic [5:0] a);
        return ADDR_CACHE_EN && vld && (cached == a);
    endfunction

    assign accept     = host.cmd_valid && host.cmd_ready;
    assign cmd_bad    = (host.cmd_addr > ADDR_MAX)
                     || (host.cmd_pair && (host.cmd_addr > (ADDR_MAX - 6'd1)))
                     || (host.cmd_write && (host.cmd_addr < WR_MIN));
    assign cmd_hit    = cache_hit(cache_vld, cache_addr, host.cmd_addr);
    assign next_addr  = addr + 6'd1;
    assign next_hit   = cache_hit(cache_vld, cache_addr, next_addr);
    assign more       = pair && !second;
    assign first_byte = host.cmd_pair ? host.cmd_wdata[15:8] : host.cmd_wdata[7:0];
    assign cur_byte   = more ? wdata[15:8] : wdata[7:0];

    assign bus_en       = bus_q.en;
    assign bus_rs       = bus_q.rs;
    assign bus_rw       = bus_q.rw;
    assign bus_data_out = bus_q.data;

    // Bus pins are loaded on the edge that enters ADDR/DATA, so they always match the registered state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            host.cmd_ready <= 1'b0;
            host.rsp_valid <= 1'b0;
            host.rsp_rdata <= 16'h0000;
            host.rsp_err   <= 1'b0;
            bus_q          <= '0;
            cache_vld      <= 1'b0;
        end else begin
            bus_q <= '0;
            case (state)
                IDLE: begin
                    host.cmd_ready <= 1'b1;
                    if (accept) begin
                        host.cmd_ready <= 1'b0;
                        host.rsp_rdata <= 16'h0000;
                        host.rsp_err   <= cmd_bad;
                        write          <= host.cmd_write;
                        pair           <= host.cmd_pair;
                        wdata          <= host.cmd_wdata;
                        addr           <= host.cmd_addr;
                        second         <= 1'b0;
                        if (cmd_bad) begin
                            state          <= RESP;
                            host.rsp_valid <= 1'b1;
                        end else begin
                            state <= cmd_hit ? DATA : ADDR;
                            bus_q <= bus_cycle(cmd_hit ? DATA : ADDR, host.cmd_addr,
                                               host.cmd_write, first_byte);
                        end
                    end
                end
                ADDR: begin
                    cache_addr <= addr;
                    cache_vld  <= 1'b1;
                    state      <= DATA;
                    bus_q      <= bus_cycle(DATA, addr, write, cur_byte);
                end
                DATA, CAPT: begin
                    // The slave drives data_out from the edge closing DATA, so sample it in CAPT.
                    if (state == CAPT) begin
                        if (more) host.rsp_rdata[15:8] <= bus_data_in;
                        else      host.rsp_rdata[7:0]  <= bus_data_in;
                    end
                    if (state == DATA && !write) begin
                        state <= CAPT;
                    end else if (more) begin
                        addr   <= next_addr;
                        second <= 1'b1;
                        state  <= next_hit ? DATA : ADDR;
                        bus_q  <= bus_cycle(next_hit ? DATA : ADDR, next_addr, write, wdata[7:0]);
                    end else begin
                        state          <= RESP;
                        host.rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (host.rsp_ready) begin
                        host.rsp_valid <= 1'b0;
                        host.cmd_ready <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regbus_host.sv
// Directed bench for regbus_host with a behavioural register-bus slave.
`timescale 1ns/1ps
module tb_regbus_host;
    import regbus_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regbus_host_if host();
    logic       bus_en, bus_rs, bus_rw;
    logic [7:0] bus_data_out, bus_data_in;

    regbus_host #(.ADDR_CACHE_EN(1'b1), .ADDR_MAX(ADDR_MAX_DEF), .WR_MIN(WR_MIN_DEF)) dut (
        .clk(clk), .reset(reset), .host(host),
        .bus_en(bus_en), .bus_rs(bus_rs), .bus_rw(bus_rw),
        .bus_data_out(bus_data_out), .bus_data_in(bus_data_in)
    );

    // Slave: latches the pointer on address cycles, writes or updates data_out on data cycles.
    logic [7:0] mem [64];
    logic [5:0] ptr = 6'd0;
    logic [7:0] sl_dout = 8'h00;
    assign bus_data_in = sl_dout;
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[CTL]  = 8'h80;
        mem[TMPH] = 8'h01;
        mem[TMPL] = 8'h9A;
    end
    always @(posedge clk) begin
        if (bus_en) begin
            if (bus_rs == RS_ADDR)        ptr <= bus_data_out[5:0];
            else if (bus_rw == RW_WRITE)  mem[ptr] <= bus_data_out;
            else                          sl_dout <= mem[ptr];
        end
    end

    // Bus activity counters and protocol watch.
    int   ph_tot = 0, en_tot = 0, viol = 0;
    logic prev_a = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            prev_a <= 1'b0;
        end else begin
            if (bus_en && !bus_rs) ph_tot <= ph_tot + 1;
            if (bus_en) en_tot <= en_tot + 1;
            if ((bus_en && !bus_rs && prev_a) || (bus_en && (host.rsp_valid || host.cmd_ready)))
                viol <= viol + 1;
            prev_a <= bus_en && !bus_rs;
        end
    end

    int n_chk = 0, n_fail = 0;
    int ph0, en0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic w, input logic p, input logic [5:0] a, input logic [15:0] wd);
        bool_wait: begin
            host.cmd_write = w; host.cmd_pair = p; host.cmd_addr = a; host.cmd_wdata = wd;
            host.cmd_valid = 1'b1;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (host.cmd_ready) break;
            end
            if (!host.cmd_ready) begin
                n_chk++; n_fail++;
                $display("FAIL accept: cmd_ready stayed 0, expected 1 within 20 cycles");
            end
            @(posedge clk); #1;
            host.cmd_valid = 1'b0;
            ph0 = ph_tot; en0 = en_tot;
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!host.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake();
        @(negedge clk); host.rsp_ready = 1'b1;
        @(posedge clk); #1; host.rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic        pr;
        logic [5:0]  a;
        logic [15:0] wd;
        logic [15:0] rd;
        logic        er;
        int          lat;
        int          ph;
    } vec_t;

    vec_t vecs [19];

    initial begin
        int lat, rv, en_exp;
        logic [15:0] rd;
        logic er;

        vecs[0]  = '{1'b0, 1'b0, CTL,    16'h0000, 16'h0080, 1'b0, 4, 1};
        vecs[1]  = '{1'b1, 1'b0, OFS_0,  16'h003C, 16'h0000, 1'b0, 3, 1};
        vecs[2]  = '{1'b0, 1'b0, OFS_0,  16'h0000, 16'h003C, 1'b0, 3, 0};
        vecs[3]  = '{1'b0, 1'b1, TMPH,   16'h0000, 16'h019A, 1'b0, 7, 2};
        vecs[4]  = '{1'b1, 1'b0, 6'd3,   16'h0055, 16'h0000, 1'b1, 1, 0};
        vecs[5]  = '{1'b0, 1'b0, 6'd31,  16'h0000, 16'h0000, 1'b1, 1, 0};
        vecs[6]  = '{1'b0, 1'b1, 6'd30,  16'h0000, 16'h0000, 1'b1, 1, 0};
        vecs[7]  = '{1'b0, 1'b0, TMPL,   16'h0000, 16'h009A, 1'b0, 3, 0};
        vecs[8]  = '{1'b1, 1'b1, 6'd29,  16'hA55A, 16'h0000, 1'b0, 5, 2};
        vecs[9]  = '{1'b0, 1'b1, 6'd29,  16'h0000, 16'hA55A, 1'b0, 7, 2};
        vecs[10] = '{1'b1, 1'b0, 6'd30,  16'h1277, 16'h0000, 1'b0, 2, 0};
        vecs[11] = '{1'b0, 1'b0, 6'd30,  16'h0000, 16'h0077, 1'b0, 3, 0};
        vecs[12] = '{1'b0, 1'b1, 6'd29,  16'h0000, 16'hA577, 1'b0, 7, 2};
        vecs[13] = '{1'b0, 1'b0, STA,    16'h0000, 16'h0000, 1'b0, 4, 1};
        vecs[14] = '{1'b1, 1'b0, CTL,    16'hFF11, 16'h0000, 1'b0, 3, 1};
        vecs[15] = '{1'b1, 1'b1, CTL,    16'hBEEF, 16'h0000, 1'b0, 4, 1};
        vecs[16] = '{1'b0, 1'b1, CTL,    16'h0000, 16'hBEEF, 1'b0, 7, 2};
        vecs[17] = '{1'b1, 1'b1, 6'd4,   16'h1111, 16'h0000, 1'b1, 1, 0};
        vecs[18] = '{1'b0, 1'b0, 6'd30,  16'h0000, 16'h0077, 1'b0, 4, 1};

        host.cmd_valid = 1'b0; host.cmd_write = 1'b0; host.cmd_pair = 1'b0;
        host.cmd_addr = 6'd0; host.cmd_wdata = 16'h0000; host.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset cmd_ready", host.cmd_ready, 0);
        chk("reset rsp_valid", host.rsp_valid, 0);
        chk("reset rsp_rdata", host.rsp_rdata, 0);
        chk("reset rsp_err", host.rsp_err, 0);
        chk("reset bus", {bus_en, bus_rs, bus_rw, bus_data_out}, 0);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            issue(vecs[i].wr, vecs[i].pr, vecs[i].a, vecs[i].wd);
            wait_rsp(lat);
            rd = host.rsp_rdata;
            er = host.rsp_err;
            handshake();
            en_exp = vecs[i].er ? 0 : vecs[i].ph + (vecs[i].pr ? 2 : 1);
            chk($sformatf("vec%0d rsp_err", i), er, vecs[i].er);
            chk($sformatf("vec%0d rsp_rdata", i), rd, vecs[i].rd);
            chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d addr phases", i), ph_tot - ph0, vecs[i].ph);
            chk($sformatf("vec%0d bus_en cycles", i), en_tot - en0, en_exp);
        end

        // Response back-pressure with a new command waiting
        issue(1'b0, 1'b0, CTL, 16'h0000);
        wait_rsp(lat);
        chk("bp latency", lat, 4);
        host.cmd_write = 1'b0; host.cmd_pair = 1'b0; host.cmd_addr = OFS_0; host.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d rsp_valid", i), host.rsp_valid, 1);
            chk($sformatf("bp%0d rsp_rdata", i), host.rsp_rdata, 16'h00BE);
            chk($sformatf("bp%0d cmd_ready", i), host.cmd_ready, 0);
        end
        @(negedge clk); host.rsp_ready = 1'b1;
        @(posedge clk); #1; host.rsp_ready = 1'b0;
        chk("bp after handshake rsp_valid", host.rsp_valid, 0);
        chk("bp after handshake cmd_ready", host.cmd_ready, 1);
        @(posedge clk); #1;
        chk("bp next accept", host.cmd_ready, 0);
        host.cmd_valid = 1'b0;
        ph0 = ph_tot;
        wait_rsp(lat);
        rd = host.rsp_rdata;
        handshake();
        chk("bp2 latency", lat, 4);
        chk("bp2 rsp_rdata", rd, 16'h003C);
        chk("bp2 addr phases", ph_tot - ph0, 1);

        // Reset during the DATA cycle of a pair write
        issue(1'b1, 1'b1, OFS_1, 16'h1234);
        @(posedge clk); #1;
        chk("rst pre bus_en", bus_en, 1);
        chk("rst pre bus_rs", bus_rs, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst bus_en", bus_en, 0);
        chk("rst rsp_valid", host.rsp_valid, 0);
        reset = 1'b0;
        rv = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (host.rsp_valid || bus_en) rv++;
        end
        chk("rst quiet after abort", rv, 0);
        issue(1'b0, 1'b0, OFS_1, 16'h0000);
        wait_rsp(lat);
        rd = host.rsp_rdata;
        handshake();
        chk("rst read latency", lat, 4);
        chk("rst read addr phases", ph_tot - ph0, 1);
        chk("rst read rsp_rdata", rd, 16'h0012);

        chk("bus protocol violations", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regbus_host.md
Name: regbus_host

Overview:
- Host-side initiator for the 8-bit RS/RW/EN register bus used by the pulse-duration temperature sensor.
- Accepts byte or byte-pair read/write commands on a valid/ready port and sequences the address-phase and data-phase bus cycles.
- Captures read data one cycle after the data phase and returns a response.
- Sits between the on-chip controller and the sensor's register interface, and is the only master on that bus.

Parameters:
- ADDR_CACHE_EN, 1: when 1, skip the address phase if the target address equals the last address written to the slave.
- ADDR_MAX, 30: highest valid slave register address.
- WR_MIN, 5: lowest writable slave register address; 0..4 are read-only.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  host can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_pair  in  1  1 = two-byte access (addr = high byte, addr+1 = low byte)
- cmd_addr  in  6  slave register address
- cmd_wdata  in  16  write data; the single-byte form uses [7:0], the pair form uses [15:8] to addr and [7:0] to addr+1
- rsp_valid  out  1  response available
- rsp_ready  in  1  response accepted
- rsp_rdata  out  16  read data; single-byte form is {8'h00, byte}; 0 for writes and errors
- rsp_err  out  1  command rejected, no bus activity
- bus_en  out  1  slave EN
- bus_rs  out  1  slave RS: 0 = address, 1 = data
- bus_rw  out  1  slave RW: 1 = write, 0 = read
- bus_data_out  out  8  drives slave data_in
- bus_data_in  in  8  from slave data_out

Behaviour:
- Reset:
  - Takes effect at the next clk edge with reset high.
  - cmd_ready=0 during reset and 1 after.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - bus_en=0, bus_rs=0, bus_rw=0, bus_data_out=0.
  - Address cache invalid; state IDLE.
- Reset mid-operation aborts the command immediately: no response is ever issued and bus_en is 0 in the next cycle.
- Bus outputs are driven from registers and decode only the registered state.
- States: IDLE, ADDR, DATA, CAPT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch the command and check it.
  - Error if any of: cmd_addr>ADDR_MAX; cmd_pair and cmd_addr>ADDR_MAX-1; cmd_write and cmd_addr<WR_MIN.
  - On error go to RESP with rsp_err=1.
  - Otherwise go to ADDR, or to DATA if ADDR_CACHE_EN, the cache is valid and the cached address equals the target.
- ADDR:
  - One cycle with bus_en=1, rs=0, rw=1, bus_data_out={2'b00, addr}.
  - Cache updated to addr and marked valid. Next state DATA.
- DATA:
  - One cycle with bus_en=1, rs=1, rw=cmd_write.
  - bus_data_out = write byte, or 0 for a read.
  - Next state: CAPT for a read; otherwise the second byte if pending, else RESP.
- CAPT (read only):
  - bus_en=0.
  - bus_data_in is registered at the end of this cycle, because the slave updates data_out on the edge that closes DATA.
- Second byte (pair): the target becomes addr+1, and the sequence re-enters through the cache check (always a miss after a first-byte ADDR phase).
- RESP:
  - rsp_valid=1 and held, with stable rsp_rdata/rsp_err, until rsp_ready.
  - The cycle rsp_valid&&rsp_ready is seen, go to IDLE.
  - cmd_ready=0 in every state except IDLE, so there is no command pipelining.
  - rsp_ready high before rsp_valid has no effect.
- Latency, counted from the accept edge to rsp_valid high:
  - read miss 4 edges; read hit 3.
  - write miss 3; write hit 2.
  - error 1.
  - pair read (first byte miss, second byte miss) 7.
- bus_en is never high for two consecutive cycles with rs=0, and is never high in IDLE or RESP.

Decomposition:
- Package regbus_pkg:
  - state enum.
  - register address constants STA=0 … GAIN3_SHA=19 (TMPH=1, TMPL=2, CTL=5, OFS_1=8, OFS_0=9).
  - WR_MIN and ADDR_MAX defaults.
  - RS/RW encodings.
- Single module; no sub-module is warranted.

Test Plan:
- Read CTL after reset, slave CTL=8'h80: ADDR cycle with bus_data_out=5, then DATA rs=1 rw=0, then CAPT → rsp_rdata=16'h0080, rsp_err=0, rsp_valid 4 edges after accept.
- Write 8'h3C to addr 9, then read addr 9: the write has an ADDR phase; the read skips ADDR (first bus cycle is the DATA cycle with rs=1) → rsp_rdata=16'h003C, latency 3.
- Pair read TMPH/TMPL at addr 1, slave holding 8'h01/8'h9A: two ADDR phases (1, then 2) → rsp_rdata=16'h019A.
- Errors: write addr 3, read addr 31, pair addr 30 → each returns rsp_err=1, rsp_rdata=0, latency 1, bus_en stays 0.
- Hold rsp_ready=0 for 5 cycles after a read: rsp_valid and rsp_rdata stay stable, cmd_ready=0, and a new cmd_valid is not accepted until one cycle after the handshake.
- Assert reset during the DATA cycle of a pair write to 8: the next cycle has bus_en=0 and no rsp_valid. A subsequent read of addr 8 performs an ADDR phase, because the cache is invalid.
